// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and FSM state type for the pipelined ALU
// Purpose: opcode encodings (OP_ADD..OP_MUL) and the control FSM state enum
//          used by alu_pipe and alu_mul_seq.
// Ports:   none (package).
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_EQ   = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add unsigned multiplier
// Purpose: one partial product per cycle over WIDTH cycles. Only built when
//          ALU_PIPE_MUL_EN is defined.
// Ports:   clk, rst (sync, active-high); start_i loads a_i/b_i;
//          busy_o high while iterating; done_o pulses on the final iteration
//          with product_o (full 2*WIDTH product) valid in that same cycle.
`ifdef ALU_PIPE_MUL_EN
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;

    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
    // Final partial product is folded in combinationally so the top can
    // capture the result on the same edge the iteration ends.
    assign product_o = acc_d;
    assign busy_o    = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with one registered output stage
// Purpose: accepts one op per in_valid/in_ready transfer, returns registered
//          result with cout/zero/ovf/err flags, holds output under backpressure.
//          Define ALU_PIPE_MUL_EN to add the multi-cycle multiply (op 11);
//          otherwise op 11 is treated as illegal.
// Ports:   clk, rst (sync, active-high)
//          in_valid/in_ready, op[3:0], a, b, cin   : operation input
//          out_valid/out_ready, result, cout, zero, ovf, err : result output
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q, zero_q, ovf_q, err_q;
    logic             accept;

    // ---------------------------------------------------------------
    // Combinational datapath
    // ---------------------------------------------------------------
    logic [SHW-1:0]          sh;
    logic [WIDTH:0]          add_w, sub_w, shl_w, srl_w;
    logic signed [WIDTH:0]   sra_w;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_c, alu_v, alu_e;

    assign sh    = b[SHW-1:0];
    assign add_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sub_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // One guard bit on the far side of each shift captures the last bit
    // shifted out; a zero shift leaves the guard at 0.
    assign shl_w = {1'b0, a} << sh;
    assign srl_w = {a, 1'b0} >> sh;
    assign sra_w = $signed({a, 1'b0}) >>> sh;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OP_SLTU: alu_c = (a < b);
            OP_EQ:   alu_c = (a == b);
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SRL: begin
                alu_res = srl_w[WIDTH:1];
                alu_c   = srl_w[0];
            end
            OP_SRA: begin
                alu_res = sra_w[WIDTH:1];
                alu_c   = sra_w[0];
            end
            OP_SLT:  alu_c = ($signed(a) < $signed(b));
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  alu_e = 1'b0;  // result comes from alu_mul_seq
`endif
            default: alu_e = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------
    // Optional multiplier
    // ---------------------------------------------------------------
    logic mul_start, mul_done;
`ifdef ALU_PIPE_MUL_EN
    logic               mul_busy;
    logic [2*WIDTH-1:0] mul_prod;

    assign mul_start = accept && (op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`else
    assign mul_start = 1'b0;
    assign mul_done  = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mul_start) begin
                    state_d = MUL;
                end
            end
            MUL: begin
`ifdef ALU_PIPE_MUL_EN
                // Leaving on !busy too keeps the FSM from wedging if the
                // multiplier ever idles without signalling done.
                if (mul_done || !mul_busy) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q != MUL) && (!out_valid_q || out_ready);
    end

    assign accept = in_valid && in_ready;

    // ---------------------------------------------------------------
    // Output register stage
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else if (mul_done) begin
`ifdef ALU_PIPE_MUL_EN
            out_valid_q <= 1'b1;
            result_q    <= mul_prod[WIDTH-1:0];
            cout_q      <= |mul_prod[2*WIDTH-1:WIDTH];
            zero_q      <= (mul_prod[WIDTH-1:0] == '0);
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else if (accept && !mul_start) begin
            // Also covers a same-edge output transfer: the new result
            // replaces the old one and out_valid stays high.
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            cout_q      <= alu_c;
            zero_q      <= (alu_res == '0);
            ovf_q       <= alu_v;
            err_q       <= alu_e;
        end else if (accept) begin
            // Multiply start: any previous result was consumed this edge.
            out_valid_q <= 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule
